// File: rtl/daq_link_framer_pkg.sv
// Shared constants and types for the DAQ link framer: K codes, FSM encodings,
// length-queue entry layout.
package daq_link_framer_pkg;

  // K-code characters used on the link
  localparam logic [7:0] IDLE_K = 8'hBC;
  localparam logic [7:0] SOE_K  = 8'h3C;
  localparam logic [7:0] EOE_K  = 8'hDC;

  localparam logic [31:0] IDLE_WORD = {4{IDLE_K}};

  // Stored payload length field width (max 2047 words per event)
  localparam int unsigned LEN_W = 11;
  // Length-queue entry width: {trunc, len}
  localparam int unsigned LQ_W  = LEN_W + 1;

  // Read FSM encodings
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SOE  = 3'd1;
  localparam logic [2:0] ST_HDR  = 3'd2;
  localparam logic [2:0] ST_PAY  = 3'd3;
  localparam logic [2:0] ST_TRL  = 3'd4;
  localparam logic [2:0] ST_EOE  = 3'd5;

  // Completed-event descriptor held in the length queue
  typedef struct packed {
    logic             trunc;
    logic [LEN_W-1:0] len;
  } lq_entry_t;

endpackage

// File: rtl/daq_framer_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on rd_data whenever
// empty is low; rd_en consumes it. Simultaneous read and write are allowed.
module daq_framer_fifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  do_wr;
  logic                  do_rd;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers and occupancy; reset flushes the FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/daq_link_framer.sv
// Buffers whole readout events, then emits each as a K-delimited link frame:
// SOE, HDR, payload, TRL (XOR checksum), EOE. Idle commas fill gaps.
module daq_link_framer
  import daq_link_framer_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2    = 11,
  parameter int unsigned MAX_EVT_WORDS = 2047,
  parameter int unsigned LQ_DEPTH      = 4
) (
  input  logic        clk_link,
  input  logic        reset,
  input  logic [7:0]  fpga_id,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] link_data,
  output logic [3:0]  link_is_k,
  output logic        link_valid,
  output logic [15:0] evt_tag,
  output logic [15:0] drop_count
);

  localparam int unsigned LQ_LOG2 = $clog2(LQ_DEPTH);

  // Write side
  logic             live_q;
  logic [LEN_W-1:0] wc_q;
  logic             wr_trunc_q;
  logic [15:0]      drop_count_q;
  logic             accept_c;
  logic             keep_c;
  logic             pay_full;
  logic             pay_empty;
  logic             pay_pop;
  logic [31:0]      pay_rdata;
  logic             lq_full;
  logic             lq_empty;
  logic             lq_pop;
  lq_entry_t        lq_wdata;
  lq_entry_t        lq_rdata;

  // Read side
  logic [2:0]       state_q,      state_d;
  logic [31:0]      link_data_q,  link_data_d;
  logic [3:0]       link_is_k_q,  link_is_k_d;
  logic             link_valid_q;
  logic [LEN_W-1:0] len_q,        len_d;
  logic             rd_trunc_q,   rd_trunc_d;
  logic [LEN_W-1:0] cnt_q,        cnt_d;
  logic [31:0]      csum_q,       csum_d;
  logic [15:0]      evt_tag_q,    evt_tag_d;

  assign in_ready   = live_q && !pay_full && !lq_full;
  assign accept_c   = in_valid && in_ready;
  assign keep_c     = (wc_q < LEN_W'(MAX_EVT_WORDS));
  assign lq_wdata   = '{trunc: wr_trunc_q || !keep_c,
                        len:   keep_c ? (wc_q + LEN_W'(1)) : wc_q};

  assign link_data  = link_data_q;
  assign link_is_k  = link_is_k_q;
  assign link_valid = link_valid_q;
  assign evt_tag    = evt_tag_q;
  assign drop_count = drop_count_q;

  daq_framer_fifo #(
    .WIDTH      (32),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_pay_fifo (
    .clk     (clk_link),
    .reset   (reset),
    .wr_en   (accept_c && keep_c),
    .wr_data (in_data),
    .rd_en   (pay_pop),
    .rd_data (pay_rdata),
    .full    (pay_full),
    .empty   (pay_empty)
  );

  daq_framer_fifo #(
    .WIDTH      (LQ_W),
    .DEPTH_LOG2 (LQ_LOG2)
  ) u_len_queue (
    .clk     (clk_link),
    .reset   (reset),
    .wr_en   (accept_c && in_last),
    .wr_data (lq_wdata),
    .rd_en   (lq_pop),
    .rd_data (lq_rdata),
    .full    (lq_full),
    .empty   (lq_empty)
  );

  // Per-event word count, truncation flag and saturating drop counter
  always_ff @(posedge clk_link) begin
    if (reset) begin
      live_q       <= 1'b0;
      wc_q         <= '0;
      wr_trunc_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      live_q <= 1'b1;
      if (accept_c) begin
        if (in_last) begin
          wc_q       <= '0;
          wr_trunc_q <= 1'b0;
        end else if (keep_c) begin
          wc_q <= wc_q + LEN_W'(1);
        end else begin
          wr_trunc_q <= 1'b1;
        end
        if (!keep_c && drop_count_q != 16'hFFFF) begin
          drop_count_q <= drop_count_q + 16'd1;
        end
      end
    end
  end

  // Frame FSM: pick the next state, then build the registered word it emits
  always_comb begin
    state_d     = state_q;
    link_data_d = IDLE_WORD;
    link_is_k_d = 4'hF;
    len_d       = len_q;
    rd_trunc_d  = rd_trunc_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    evt_tag_d   = evt_tag_q;
    lq_pop      = 1'b0;
    pay_pop     = 1'b0;

    case (state_q)
      ST_IDLE: if (!lq_empty) state_d = ST_SOE;
      ST_SOE:  state_d = ST_HDR;
      ST_HDR:  state_d = ST_PAY;
      ST_PAY:  if (cnt_q == '0) state_d = ST_TRL;
      ST_TRL:  state_d = ST_EOE;
      ST_EOE:  state_d = lq_empty ? ST_IDLE : ST_SOE;
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_SOE: begin
        link_data_d = {fpga_id, evt_tag_q, SOE_K};
        link_is_k_d = 4'h1;
        lq_pop      = 1'b1;
        len_d       = lq_rdata.len;
        rd_trunc_d  = lq_rdata.trunc;
      end
      ST_HDR: begin
        link_data_d = {rd_trunc_q, 4'h0, len_q, evt_tag_q};
        link_is_k_d = 4'h0;
        csum_d      = link_data_d;
        cnt_d       = len_q;
      end
      ST_PAY: begin
        link_data_d = pay_rdata;
        link_is_k_d = 4'h0;
        pay_pop     = 1'b1;
        csum_d      = csum_q ^ pay_rdata;
        cnt_d       = cnt_q - LEN_W'(1);
      end
      ST_TRL: begin
        link_data_d = csum_q;
        link_is_k_d = 4'h0;
      end
      ST_EOE: begin
        link_data_d = {24'h0, EOE_K};
        link_is_k_d = 4'h1;
        evt_tag_d   = evt_tag_q + 16'd1;
      end
      default: ;
    endcase
  end

  // FSM state and registered link outputs; reset abandons any open frame
  always_ff @(posedge clk_link) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      link_data_q  <= IDLE_WORD;
      link_is_k_q  <= 4'hF;
      link_valid_q <= 1'b0;
      len_q        <= '0;
      rd_trunc_q   <= 1'b0;
      cnt_q        <= '0;
      csum_q       <= '0;
      evt_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      link_data_q  <= link_data_d;
      link_is_k_q  <= link_is_k_d;
      link_valid_q <= 1'b1;
      len_q        <= len_d;
      rd_trunc_q   <= rd_trunc_d;
      cnt_q        <= cnt_d;
      csum_q       <= csum_d;
      evt_tag_q    <= evt_tag_d;
    end
  end

endmodule

// File: tb/tb_daq_link_framer.sv
// Directed bench for daq_link_framer: reset, single frame, back-to-back frames
// with queue backpressure, truncation, tag wrap and mid-frame reset.
module tb_daq_link_framer;

  localparam int unsigned DEPTH_LOG2    = 4;
  localparam int unsigned MAX_EVT_WORDS = 8;
  localparam int unsigned LQ_DEPTH      = 4;
  localparam logic [31:0] IDLE_W        = 32'hBCBCBCBC;

  logic        clk_link = 1'b0;
  logic        reset    = 1'b1;
  logic [7:0]  fpga_id  = 8'h5A;
  logic [31:0] in_data  = '0;
  logic        in_valid = 1'b0;
  logic        in_last  = 1'b0;
  logic        in_ready;
  logic [31:0] link_data;
  logic [3:0]  link_is_k;
  logic        link_valid;
  logic [15:0] evt_tag;
  logic [15:0] drop_count;

  int          n_chk  = 0;
  int          n_fail = 0;
  bit          saw_stall = 1'b0;
  logic [36:0] cap[$];

  daq_link_framer #(
    .DEPTH_LOG2    (DEPTH_LOG2),
    .MAX_EVT_WORDS (MAX_EVT_WORDS),
    .LQ_DEPTH      (LQ_DEPTH)
  ) dut (
    .clk_link   (clk_link),
    .reset      (reset),
    .fpga_id    (fpga_id),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .link_data  (link_data),
    .link_is_k  (link_is_k),
    .link_valid (link_valid),
    .evt_tag    (evt_tag),
    .drop_count (drop_count)
  );

  always #5 clk_link = ~clk_link;

  // Record every link word {valid, is_k, data} away from the active edge
  always @(negedge clk_link) cap.push_back({link_valid, link_is_k, link_data});

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_event(input logic [31:0] w[$]);
    for (int i = 0; i < w.size(); i++) begin
      int unsigned wait_n;
      wait_n   = 0;
      in_data  = w[i];
      in_valid = 1'b1;
      in_last  = (i == w.size() - 1);
      while (!in_ready && wait_n < 200) begin
        saw_stall = 1'b1;
        @(negedge clk_link);
        wait_n++;
      end
      if (!in_ready) chk("in_ready_timeout", in_ready, 1);
      @(posedge clk_link);
      @(negedge clk_link);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_link);
    reset = 1'b0;
    @(negedge clk_link);
  endtask

  function automatic int find_soe(input int from);
    for (int i = from; i < cap.size(); i++) begin
      if (cap[i][36] && cap[i][35:32] == 4'h1 && cap[i][7:0] == 8'h3C) return i;
    end
    return -1;
  endfunction

  function automatic logic [36:0] cap_at(input int i);
    if (i >= 0 && i < cap.size()) return cap[i];
    return 'x;
  endfunction

  // Expected frame built from the event contents and tag
  task automatic check_frame(input string nm, inout int idx, input logic [15:0] tag,
                             input logic [31:0] pl[$], input logic trunc);
    logic [31:0] hdr;
    logic [31:0] cs;
    hdr = {trunc, 4'h0, 11'(pl.size()), tag};
    cs  = hdr;
    chk({nm, "_soe"}, cap_at(idx), {1'b1, 4'h1, fpga_id, tag, 8'h3C}); idx++;
    chk({nm, "_hdr"}, cap_at(idx), {1'b1, 4'h0, hdr});                 idx++;
    foreach (pl[k]) begin
      chk($sformatf("%s_pay%0d", nm, k), cap_at(idx), {1'b1, 4'h0, pl[k]});
      cs = cs ^ pl[k];
      idx++;
    end
    chk({nm, "_trl"}, cap_at(idx), {1'b1, 4'h0, cs});                  idx++;
    chk({nm, "_eoe"}, cap_at(idx), {1'b1, 4'h1, 24'h0, 8'hDC});        idx++;
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] pl[$];
    int          base;
    int          idx;
    int          n;
    int          bad;

    // 1: reset values, then live outputs
    repeat (5) @(negedge clk_link);
    chk("t1_rst_valid", link_valid, 0);
    chk("t1_rst_data",  link_data,  IDLE_W);
    chk("t1_rst_isk",   link_is_k,  4'hF);
    chk("t1_rst_ready", in_ready,   0);
    chk("t1_rst_tag",   evt_tag,    0);
    chk("t1_rst_drop",  drop_count, 0);
    reset = 1'b0;
    @(negedge clk_link);
    chk("t1_valid", link_valid, 1);
    chk("t1_ready", in_ready,   1);
    chk("t1_idle",  link_data,  IDLE_W);

    // 2: three-word event, hand-computed frame, SOE two cycles after in_last
    q = {32'h11, 32'h22, 32'h33};
    send_event(q);
    chk("t2_gap_data", link_data, IDLE_W);
    chk("t2_gap_isk",  link_is_k, 4'hF);
    @(negedge clk_link);
    chk("t2_soe", {link_is_k, link_data}, {4'h1, 32'h5A00003C});
    @(negedge clk_link);
    chk("t2_hdr", {link_is_k, link_data}, {4'h0, 32'h00030000});
    @(negedge clk_link);
    chk("t2_p0",  {link_is_k, link_data}, {4'h0, 32'h00000011});
    @(negedge clk_link);
    chk("t2_p1",  {link_is_k, link_data}, {4'h0, 32'h00000022});
    @(negedge clk_link);
    chk("t2_p2",  {link_is_k, link_data}, {4'h0, 32'h00000033});
    @(negedge clk_link);
    chk("t2_trl", {link_is_k, link_data}, {4'h0, 32'h00030000});
    @(negedge clk_link);
    chk("t2_eoe", {link_is_k, link_data}, {4'h1, 32'h000000DC});
    @(negedge clk_link);
    chk("t2_idle", {link_valid, link_is_k, link_data}, {1'b1, 4'hF, IDLE_W});
    chk("t2_tag",  evt_tag, 16'd1);

    // 3: six one-word events back-to-back; length queue fills, frames contiguous
    do_reset();
    base      = cap.size();
    saw_stall = 1'b0;
    for (int e = 0; e < 6; e++) begin
      q.delete();
      q.push_back(32'(32'h100 + e));
      send_event(q);
    end
    repeat (40) @(negedge clk_link);
    chk("t3_stall", saw_stall, 1);
    idx = find_soe(base);
    chk("t3_found", idx >= 0, 1);
    for (int e = 0; e < 6; e++) begin
      pl.delete();
      pl.push_back(32'(32'h100 + e));
      check_frame($sformatf("t3_f%0d", e), idx, 16'(e), pl, 1'b0);
    end
    chk("t3_idle_after", cap_at(idx), {1'b1, 4'hF, IDLE_W});
    chk("t3_tag", evt_tag, 16'd6);

    // 4: 12-word event truncated to 8 stored words
    do_reset();
    base = cap.size();
    q.delete();
    for (int i = 0; i < 12; i++) q.push_back(32'(32'hA0 + i));
    send_event(q);
    repeat (20) @(negedge clk_link);
    idx = find_soe(base);
    pl.delete();
    for (int i = 0; i < 8; i++) pl.push_back(32'(32'hA0 + i));
    chk("t4_hdr_raw", cap_at(idx + 1), {1'b1, 4'h0, 32'h80080000});
    chk("t4_trl_raw", cap_at(idx + 10), {1'b1, 4'h0, 32'h80080000});
    check_frame("t4", idx, 16'h0000, pl, 1'b1);
    chk("t4_drop", drop_count, 16'd4);

    // 5: tag wrap FFFF -> 0000
    force dut.evt_tag_q = 16'hFFFF;
    @(negedge clk_link);
    release dut.evt_tag_q;
    @(negedge clk_link);
    chk("t5_tag_ffff", evt_tag, 16'hFFFF);
    base = cap.size();
    q = {32'hCAFEF00D};
    send_event(q);
    q = {32'h12345678};
    send_event(q);
    repeat (20) @(negedge clk_link);
    idx = find_soe(base);
    pl = {32'hCAFEF00D};
    check_frame("t5_ffff", idx, 16'hFFFF, pl, 1'b0);
    pl = {32'h12345678};
    check_frame("t5_0000", idx, 16'h0000, pl, 1'b0);
    chk("t5_tag_after", evt_tag, 16'h0001);

    // 6: reset during payload of a 10-word event
    do_reset();
    q.delete();
    for (int i = 0; i < 10; i++) q.push_back(32'(32'hB0 + i));
    send_event(q);
    n = 0;
    while (!(link_valid && link_is_k == 4'h0) && n < 40) begin
      @(negedge clk_link);
      n++;
    end
    chk("t6_hdr_seen", link_data, 32'h80080000);
    @(negedge clk_link);
    chk("t6_pay0", link_data, 32'hB0);
    chk("t6_drop_pre", drop_count, 16'd2);
    reset = 1'b1;
    @(negedge clk_link);
    chk("t6_rst_word", {link_valid, link_is_k, link_data}, {1'b0, 4'hF, IDLE_W});
    reset = 1'b0;
    @(negedge clk_link);
    chk("t6_idle_word", {link_valid, link_is_k, link_data}, {1'b1, 4'hF, IDLE_W});
    chk("t6_tag",   evt_tag,    16'd0);
    chk("t6_drop",  drop_count, 16'd0);
    chk("t6_ready", in_ready,   1);
    bad = 0;
    repeat (12) begin
      @(negedge clk_link);
      if ({link_valid, link_is_k, link_data} !== {1'b1, 4'hF, IDLE_W}) bad++;
    end
    chk("t6_quiet", bad, 0);
    base = cap.size();
    q = {32'hDEADBEEF};
    send_event(q);
    repeat (15) @(negedge clk_link);
    idx = find_soe(base);
    pl = {32'hDEADBEEF};
    check_frame("t6_new", idx, 16'h0000, pl, 1'b0);
    chk("t6_idle_after", cap_at(idx), {1'b1, 4'hF, IDLE_W});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
